// File: rtl/grid_memory_port_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and
// grid_memory_port_ctrl (slave).
interface grid_memory_port_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/grid_memory_port_ctrl.sv
// Front-end for the fabric memory tile: registered pin drive, in-order read
// responses through a credit-protected FIFO, and zero-fill of the whole tile.
module grid_memory_port_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RSP_DEPTH     = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  grid_memory_port_ctrl_if.slave bus,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_d_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_d_out
);
  localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned UW   = CW + 1;
  localparam int unsigned CNTW = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESET = INIT_ON_RESET ? ST_INIT : ST_RUN;

  logic [1:0]            state_q, state_d;
  logic [CNTW-1:0]       init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_d_in_q, mem_d_in_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  rd_s1_q, rd_s1_d;
  logic                  rd_s2_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [UW-1:0]         used;
  logic                  ready, accept, push, pop;

  // Credits cover reads still in the memory pipeline as well as queued data.
  assign used   = UW'(cnt_q) + UW'(rd_s1_q) + UW'(rd_s2_q);
  assign ready  = (state_q == ST_RUN) && (used < UW'(RSP_DEPTH));
  assign accept = bus.req_valid && ready;
  assign push   = rd_s2_q;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_rdata = fifo_q[rd_ptr_q];
  assign init_busy     = (state_q != ST_RUN);
  assign mem_addr      = mem_addr_q;
  assign mem_d_in      = mem_d_in_q;
  assign mem_wen       = mem_wen_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_d_in_d = mem_d_in_q;
    mem_wen_d  = 1'b0;
    rd_s1_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // The extra counter bit marks that the last address has been written.
        if (init_cnt_q[ADDR_WIDTH]) begin
          state_d = ST_RUN;
        end else begin
          mem_addr_d = init_cnt_q[ADDR_WIDTH-1:0];
          mem_d_in_d = '0;
          mem_wen_d  = 1'b1;
          init_cnt_d = init_cnt_q + CNTW'(1);
        end
      end
      ST_RUN: begin
        if (accept) begin
          mem_addr_d = bus.req_addr;
          mem_wen_d  = bus.req_we;
          rd_s1_d    = !bus.req_we;
          if (bus.req_we) mem_d_in_d = bus.req_wdata;
        end
        if (init_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_s1_q && !rd_s2_q) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      init_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_d_in_q <= '0;
      mem_wen_q  <= 1'b0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_d_in_q <= mem_d_in_d;
      mem_wen_q  <= mem_wen_d;
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s1_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_d_out;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CW'(RSP_DEPTH))));
endmodule

// File: tb/tb_grid_memory_port_ctrl.sv
// Directed bench for grid_memory_port_ctrl with a registered-read memory tile model.
module tb_grid_memory_port_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_req, init_busy, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_in, mem_d_out;

  always #5 clk = ~clk;

  grid_memory_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  grid_memory_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(4), .INIT_ON_RESET(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_req(init_req), .init_busy(init_busy),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_wen(mem_wen), .mem_d_out(mem_d_out)
  );

  // Never-written locations read back 0xFF so the zero-fill is observable.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  bit            mem_ok [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr]    <= mem_d_in;
      mem_ok[mem_addr] <= 1'b1;
    end
    mem_d_out <= mem_ok[mem_addr] ? mem[mem_addr] : 8'hFF;
  end

  int unsigned checks = 0, failures = 0, stalls = 0;
  int unsigned acc, got, gap, bad;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned i);
    return DW'((i * 37 + 5) & 255);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk); n++; stalls++;
    end
    check("send_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic watch_init(input string tag, input logic keep_valid);
    int unsigned wen_n = 0, errs = 0, lost = 0, guard = 0;
    while (init_busy && guard < 3000) begin
      if (mem_wen) begin
        if (mem_addr !== AW'(wen_n) || mem_d_in !== '0) errs++;
        wen_n++;
      end else if (wen_n > 0 && wen_n < 1024) begin
        errs++;
      end
      if (bus.rsp_valid !== keep_valid) lost++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_wen_cycles"}, wen_n, 32'd1024);
    check({tag, "_seq_errs"}, errs, 32'd0);
    check({tag, "_rsp_valid"}, lost, 32'd0);
    check({tag, "_busy_end"}, 32'(init_busy), 32'd0);
    check({tag, "_ready_end"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_wen_end"}, 32'(mem_wen), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; init_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    watch_init("por", 1'b0);

    // Read of the last address after zero-fill, latency 2
    bus.rsp_ready = 1'b1;
    send(1'b0, 10'h3FF, 8'h00);
    bus.req_valid = 1'b0;
    check("a_addr", 32'(mem_addr), 32'h3FF);
    check("a_wen", 32'(mem_wen), 32'd0);
    check("a_lat0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("a_lat1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("a_lat2", 32'(bus.rsp_valid), 32'd1);
    check("a_rdata", 32'(bus.rsp_rdata), 32'h00);
    @(negedge clk); check("a_popped", 32'(bus.rsp_valid), 32'd0);

    // Write then immediate read of the same address
    send(1'b1, 10'h012, 8'h5A);
    check("b_wr_wen", 32'(mem_wen), 32'd1);
    check("b_wr_addr", 32'(mem_addr), 32'h012);
    check("b_wr_din", 32'(mem_d_in), 32'h5A);
    send(1'b0, 10'h012, 8'hEE);
    bus.req_valid = 1'b0;
    check("b_rd_wen", 32'(mem_wen), 32'd0);
    check("b_rd_din_hold", 32'(mem_d_in), 32'h5A);
    check("b_lat0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("b_lat1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); check("b_lat2", 32'(bus.rsp_valid), 32'd1);
    check("b_rdata", 32'(bus.rsp_rdata), 32'h5A);
    @(negedge clk);

    for (int i = 0; i < 16; i++) send(1'b1, 10'h100 + AW'(i), pat(i));
    bus.req_valid = 1'b0;
    @(negedge clk);

    // 16 back-to-back reads with the consumer always ready
    stalls = 0; got = 0; gap = 0; bad = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(1'b0, 10'h100 + AW'(i), 8'h00);
        bus.req_valid = 1'b0;
      end
      begin
        repeat (30) begin
          if (bus.rsp_valid) begin
            if (bus.rsp_rdata !== pat(got)) bad++;
            got++;
          end else if (got > 0 && got < 16) begin
            gap++;
          end
          @(negedge clk);
        end
      end
    join
    check("c_count", got, 32'd16);
    check("c_data_errs", bad, 32'd0);
    check("c_gaps", gap, 32'd0);
    check("c_stalls", stalls, 32'd0);

    // Consumer stalled: credits stop acceptance at 4
    bus.rsp_ready = 1'b0; acc = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h100;
    repeat (12) begin
      if (bus.req_ready) acc++;
      @(negedge clk);
      bus.req_addr = 10'h100 + AW'(acc);
    end
    bus.req_valid = 1'b0;
    check("d_accepted", acc, 32'd4);
    check("d_ready_low", 32'(bus.req_ready), 32'd0);
    check("d_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("d_rdata", 32'(bus.rsp_rdata), 32'(pat(k)));
      @(negedge clk);
    end
    check("d_empty", 32'(bus.rsp_valid), 32'd0);
    check("d_ready_back", 32'(bus.req_ready), 32'd1);

    // init_req with one response queued and two reads in flight
    bus.rsp_ready = 1'b0;
    send(1'b0, 10'h012, 8'h00);
    send(1'b0, 10'h100, 8'h00);
    send(1'b0, 10'h101, 8'h00);
    bus.req_valid = 1'b0;
    init_req = 1'b1;
    check("e_busy_pre", 32'(init_busy), 32'd0);
    @(negedge clk);
    init_req = 1'b0;
    check("e_busy", 32'(init_busy), 32'd1);
    check("e_ready", 32'(bus.req_ready), 32'd0);
    watch_init("drain", 1'b1);
    bus.rsp_ready = 1'b1;
    check("e_rsp0", 32'(bus.rsp_rdata), 32'h5A);
    @(negedge clk); check("e_rsp1", 32'(bus.rsp_rdata), 32'(pat(0)));
    @(negedge clk); check("e_rsp2", 32'(bus.rsp_rdata), 32'(pat(1)));
    @(negedge clk); check("e_empty", 32'(bus.rsp_valid), 32'd0);
    send(1'b0, 10'h100, 8'h00);
    bus.req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("e_zero_valid", 32'(bus.rsp_valid), 32'd1);
    check("e_zero_data", 32'(bus.rsp_rdata), 32'h00);
    @(negedge clk);

    // Asynchronous reset in the middle of a burst
    bus.rsp_ready = 1'b0;
    send(1'b0, 10'h001, 8'h00);
    send(1'b0, 10'h002, 8'h00);
    send(1'b1, 10'h200, 8'h77);
    bus.req_valid = 1'b0;
    check("f_wen_pre", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("f_wen", 32'(mem_wen), 32'd0);
    check("f_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("f_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("f_busy", 32'(init_busy), 32'd1);
    check("f_ready", 32'(bus.req_ready), 32'd0);
    check("f_addr", 32'(mem_addr), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    watch_init("rst", 1'b0);
    check("f_empty_after", 32'(bus.rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
